sync_fifo_flags: RTL and testbench
==================================

Name: sync_fifo_flags

Overview:
Single-clock, parametrised FIFO for buffering bytes and packets inside one clock domain, for example between the packetizer FSM and the UART transmitter.
- Generalises the existing dual-clock FIFO.
- Adds a fill-level output and programmable almost-full / almost-empty flags.
- Adds a selectable first-word-fall-through read mode, a synchronous flush, and sticky overflow/underflow error flags.

Parameters:
- DATA_WIDTH, 8: width of one data word.
- ADDR_WIDTH, 4: address width; capacity is DEPTH = 1<<ADDR_WIDTH words (power of two only).
- AFULL_THRESH, DEPTH-2: almost_full asserts when fill_count >= this value; legal range 1..DEPTH.
- AEMPTY_THRESH, 1: almost_empty asserts when fill_count <= this value; legal range 0..DEPTH-1.
- FWFT, 0: read mode. 0 = standard (registered read, 1-cycle latency); 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of contents and error flags.
- wr_data_in  in  DATA_WIDTH  write data.
- wr_en  in  1  write request.
- fifo_full  out  1  fill_count == DEPTH.
- almost_full  out  1  fill_count >= AFULL_THRESH.
- rd_en  in  1  read request (FWFT=1: acknowledge of the head word).
- rd_data_out  out  DATA_WIDTH  read data.
- fifo_empty  out  1  fill_count == 0.
- almost_empty  out  1  fill_count <= AEMPTY_THRESH.
- data_out_valid  out  1  rd_data_out holds a valid word.
- fill_count  out  ADDR_WIDTH+1  current number of stored words, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst=1 at a clock edge) clears all state:
  - Pointers and fill_count = 0; fifo_empty = 1; almost_empty = 1.
  - fifo_full = 0; almost_full = 0 (AFULL_THRESH >= 1).
  - data_out_valid = 0; overflow = 0; underflow = 0.
  - rd_data_out = 0 when FWFT=0.
  - Memory contents are not reset.
- Priority: rst > flush > normal operation.
- Flush gives the same result as reset, except that the memory and the FWFT=0 rd_data_out register hold their values. wr_en and rd_en in the flush cycle are ignored and do not set error flags.
- Accept conditions: push = wr_en & ~fifo_full; pop = rd_en & ~fifo_empty.
  - Both are evaluated against the registered flags as they stand at the edge.
  - Write while full is dropped even if a pop happens in the same cycle.
- Pointers: rd_ptr and wr_ptr are ADDR_WIDTH-bit and wrap modulo DEPTH. fill_count is tracked separately.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: count unchanged, both pointers advance.
  - A simultaneous push and pop on an empty FIFO cannot occur, because pop is blocked while empty.
- Flag timing: all flags are registered and computed from the next count. They always equal their defining function of the current fill_count, and update in the cycle after the causing push/pop.
- Write latency: data written at edge N is readable from edge N+1. fifo_empty falls at N+1.
- FWFT=0 read:
  - On pop at edge N, rd_data_out <= mem[rd_ptr] and data_out_valid = 1 during cycle N+1.
  - data_out_valid = 0 in any cycle not preceded by a pop.
  - rd_data_out holds its last value otherwise.
- FWFT=1 read:
  - rd_data_out = mem[rd_ptr], combinational from registered state.
  - data_out_valid = ~fifo_empty.
  - rd_en while valid consumes the word; the next word (if any) appears in the following cycle.
- Error flags:
  - overflow <= 1 when wr_en & fifo_full.
  - underflow <= 1 when rd_en & fifo_empty.
  - Both hold until rst or flush.
  - A rejected access never changes pointers, count or memory.
- Elaboration check: the build fails on thresholds outside their legal range or DEPTH != 1<<ADDR_WIDTH.

Decomposition:
- Shared package/header holds:
  - Default width/depth constants.
  - Read-mode constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1, used by this block and the packetizer.
- One sub-module, fifo_ram: simple dual-port memory with one write port and an asynchronous read port, DATA_WIDTH x DEPTH. The control, count and flag logic stays in sync_fifo_flags.

Test Plan:
(All cases use DATA_WIDTH=8, ADDR_WIDTH=2, i.e. DEPTH=4, AFULL_THRESH=3, AEMPTY_THRESH=1.)
- Fill and drain (FWFT=0):
  - Write 0xA1, 0xA2, 0xA3, 0xA4 on consecutive cycles → fill_count goes 1, 2, 3, 4.
  - almost_full rises with count 3; fifo_full rises with count 4; almost_empty falls at count 2.
  - 4 reads → rd_data_out A1..A4, each with a 1-cycle data_out_valid pulse the cycle after the pop.
  - Ends with fifo_empty = 1.
- Overflow/underflow:
  - At full, wr_en with 0xFF → overflow = 1, fill_count stays 4, 0xFF is never read back.
  - Drain to empty, then rd_en → underflow = 1, count stays 0.
  - Flush → both flags 0.
- Simultaneous access:
  - With count 2 (0x10, 0x11), write 0x12 and read in the same cycle → count stays 2, read returns 0x10.
  - At full, write plus read → read succeeds, write is dropped, count becomes 3, overflow = 1.
- Wrap-around: push/pop 10 words (0x00..0x09) while keeping count ≤ 2 → output order is exact and pointers wrap twice.
- FWFT=1:
  - Write 0x5A into empty → next cycle data_out_valid = 1 and rd_data_out = 0x5A with no rd_en.
  - rd_en → next cycle fifo_empty = 1 and data_out_valid = 0.
- Reset/flush mid-operation:
  - With count 3, assert flush together with wr_en → next cycle count = 0, fifo_empty = 1, flags cleared, write ignored.
  - Repeat with rst → same result, plus rd_data_out = 0 for FWFT=0.

Source files
------------

// File: rtl/sync_fifo_flags_pkg.sv
// ----------------------------------------------------------------------------
// sync_fifo_flags_pkg
// Shared constants for the single-clock FIFO and its users (e.g. packetizer).
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH : default word width and address width
//   FIFO_MODE_STD / FIFO_MODE_FWFT  : read-mode selector values for FWFT
//   fifo_depth()                    : capacity in words for an address width
// ----------------------------------------------------------------------------
package sync_fifo_flags_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 4;

   localparam int FIFO_MODE_STD  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   function automatic int fifo_depth(input int addr_width);
      return 1 << addr_width;
   endfunction

endpackage

// File: rtl/sync_fifo_flags_ram.sv
// ----------------------------------------------------------------------------
// fifo_ram
// Simple dual-port storage for the FIFO: one synchronous write port and one
// asynchronous read port, DATA_WIDTH x (1 << ADDR_WIDTH). Contents are never
// reset.
//   clk      : write clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address
//   rd_data  : combinational read data at rd_addr
// ----------------------------------------------------------------------------
module fifo_ram
   import sync_fifo_flags_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int DEPTH = fifo_depth(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// ----------------------------------------------------------------------------
// sync_fifo_flags
// Single-clock FIFO with fill level, programmable almost-full/almost-empty
// flags, selectable standard or first-word-fall-through read, synchronous
// flush and sticky overflow/underflow flags.
//   clk, rst        : clock, synchronous active-high reset
//   flush           : synchronous clear of contents and error flags
//   wr_data_in/wr_en: write port; fifo_full / almost_full status
//   rd_en           : read request (FWFT: acknowledge of the head word)
//   rd_data_out     : read data, qualified by data_out_valid
//   fifo_empty / almost_empty : empty-side status
//   fill_count      : number of stored words, 0..DEPTH
//   overflow / underflow : sticky rejected-access flags
// ----------------------------------------------------------------------------
module sync_fifo_flags
   import sync_fifo_flags_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
   parameter int AFULL_THRESH  = fifo_depth(ADDR_WIDTH) - 2,
   parameter int AEMPTY_THRESH = 1,
   parameter int FWFT          = FIFO_MODE_STD
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] wr_data_in,
   input  logic                  wr_en,
   output logic                  fifo_full,
   output logic                  almost_full,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data_out,
   output logic                  fifo_empty,
   output logic                  almost_empty,
   output logic                  data_out_valid,
   output logic [ADDR_WIDTH:0]   fill_count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int CNT_W = ADDR_WIDTH + 1;
   localparam int DEPTH = fifo_depth(ADDR_WIDTH);

   localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AFULL_CNT  = CNT_W'(AFULL_THRESH);
   localparam logic [CNT_W-1:0] AEMPTY_CNT = CNT_W'(AEMPTY_THRESH);

   // Refuse to build with an unusable geometry, threshold or read mode.
   if (ADDR_WIDTH < 1 || DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
      $error("sync_fifo_flags: DEPTH must equal 1 << ADDR_WIDTH with ADDR_WIDTH >= 1");
   end
   if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
      $error("sync_fifo_flags: AFULL_THRESH must lie in 1..DEPTH");
   end
   if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
      $error("sync_fifo_flags: AEMPTY_THRESH must lie in 0..DEPTH-1");
   end
   if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
      $error("sync_fifo_flags: FWFT must be FIFO_MODE_STD or FIFO_MODE_FWFT");
   end

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  afull_q, afull_d;
   logic                  aempty_q, aempty_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  valid_q, valid_d;

   logic                  push;
   logic                  pop;
   logic                  ram_we;
   logic [DATA_WIDTH-1:0] ram_rd_data;

   fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (ram_we),
      .wr_addr (wr_ptr_q),
      .wr_data (wr_data_in),
      .rd_addr (rd_ptr_q),
      .rd_data (ram_rd_data)
   );

   // Accepts are judged against the registered flags, so a write at full is
   // dropped even when a pop frees a slot in the same cycle. Flush and reset
   // cycles must not touch memory either.
   assign push   = wr_en & ~full_q;
   assign pop    = rd_en & ~empty_q;
   assign ram_we = push & ~flush & ~rst;

   // Next-state for pointers, count, read register and error flags. The
   // status flags are derived from the next count so that they track
   // fill_count exactly, one cycle after the causing access.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      udf_d     = udf_q;
      rd_data_d = rd_data_q;
      valid_d   = 1'b0;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_data_d = ram_rd_data;
            valid_d   = 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
         ovf_d = ovf_q | (wr_en & full_q);
         udf_d = udf_q | (rd_en & empty_q);
      end

      full_d   = (count_d == DEPTH_CNT);
      empty_d  = (count_d == '0);
      afull_d  = (count_d >= AFULL_CNT);
      aempty_d = (count_d <= AEMPTY_CNT);
   end

   // Single register stage; reset clears everything except the memory.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         afull_q   <= 1'b0;
         aempty_q  <= 1'b1;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
         rd_data_q <= '0;
         valid_q   <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         full_q    <= full_d;
         empty_q   <= empty_d;
         afull_q   <= afull_d;
         aempty_q  <= aempty_d;
         ovf_q     <= ovf_d;
         udf_q     <= udf_d;
         rd_data_q <= rd_data_d;
         valid_q   <= valid_d;
      end
   end

   // In FWFT mode the head word is presented straight from memory whenever
   // the FIFO holds something; otherwise the registered read is used.
   assign rd_data_out    = (FWFT == FIFO_MODE_FWFT) ? ram_rd_data : rd_data_q;
   assign data_out_valid = (FWFT == FIFO_MODE_FWFT) ? ~empty_q : valid_q;

   assign fifo_full    = full_q;
   assign almost_full  = afull_q;
   assign fifo_empty   = empty_q;
   assign almost_empty = aempty_q;
   assign fill_count   = count_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo_flags
// Drives a standard-read and an FWFT instance (DEPTH=4, AFULL=3, AEMPTY=1)
// with identical stimulus and compares both against a queue-based model.
// ----------------------------------------------------------------------------
module tb_sync_fifo_flags;

   localparam int DW    = 8;
   localparam int AW    = 2;
   localparam int DEPTH = 4;
   localparam int AFT   = 3;
   localparam int AET   = 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic [DW-1:0] wr_data = '0;

   logic          s_full, s_afull, s_empty, s_aempty, s_valid, s_ovf, s_udf;
   logic [DW-1:0] s_data;
   logic [AW:0]   s_count;
   logic          f_full, f_afull, f_empty, f_aempty, f_valid, f_ovf, f_udf;
   logic [DW-1:0] f_data;
   logic [AW:0]   f_count;

   int passCount = 0;
   int totalCount = 0;

   // Reference model state
   logic [DW-1:0] modelQ[$];
   bit            modelOvf = 1'b0;
   bit            modelUdf = 1'b0;
   logic [DW-1:0] modelStdData = '0;
   bit            modelStdValid = 1'b0;

   always #5 clk = ~clk;

   sync_fifo_flags #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AFT),
      .AEMPTY_THRESH(AET), .FWFT(0)
   ) dut_std (
      .clk(clk), .rst(rst), .flush(flush), .wr_data_in(wr_data), .wr_en(wr_en),
      .fifo_full(s_full), .almost_full(s_afull), .rd_en(rd_en),
      .rd_data_out(s_data), .fifo_empty(s_empty), .almost_empty(s_aempty),
      .data_out_valid(s_valid), .fill_count(s_count), .overflow(s_ovf),
      .underflow(s_udf)
   );

   sync_fifo_flags #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AFT),
      .AEMPTY_THRESH(AET), .FWFT(1)
   ) dut_fwft (
      .clk(clk), .rst(rst), .flush(flush), .wr_data_in(wr_data), .wr_en(wr_en),
      .fifo_full(f_full), .almost_full(f_afull), .rd_en(rd_en),
      .rd_data_out(f_data), .fifo_empty(f_empty), .almost_empty(f_aempty),
      .data_out_valid(f_valid), .fill_count(f_count), .overflow(f_ovf),
      .underflow(f_udf)
   );

   // One comparison: counted, and reported as a FAIL line when wrong.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Advance the model by one clock edge using the FIFO rules directly:
   // a queue of words, full/empty judged before the edge.
   task automatic modelStep(input bit w, input logic [DW-1:0] d, input bit r,
                            input bit f, input bit rs);
      int  size;
      bit  wasFull;
      bit  wasEmpty;
      size     = modelQ.size();
      wasFull  = (size == DEPTH);
      wasEmpty = (size == 0);
      if (rs) begin
         modelQ.delete();
         modelOvf      = 1'b0;
         modelUdf      = 1'b0;
         modelStdData  = '0;
         modelStdValid = 1'b0;
      end else if (f) begin
         modelQ.delete();
         modelOvf      = 1'b0;
         modelUdf      = 1'b0;
         modelStdValid = 1'b0;
      end else begin
         if (w && wasFull)  modelOvf = 1'b1;
         if (r && wasEmpty) modelUdf = 1'b1;
         if (r && !wasEmpty) begin
            modelStdData  = modelQ.pop_front();
            modelStdValid = 1'b1;
         end else begin
            modelStdValid = 1'b0;
         end
         if (w && !wasFull) modelQ.push_back(d);
      end
   endtask

   // Compare every output of both instances against the model.
   task automatic checkOutput();
      int n;
      n = modelQ.size();
      check("std count",  32'(s_count),  32'(n));
      check("std full",   32'(s_full),   32'(n == DEPTH));
      check("std empty",  32'(s_empty),  32'(n == 0));
      check("std afull",  32'(s_afull),  32'(n >= AFT));
      check("std aempty", 32'(s_aempty), 32'(n <= AET));
      check("std ovf",    32'(s_ovf),    32'(modelOvf));
      check("std udf",    32'(s_udf),    32'(modelUdf));
      check("std valid",  32'(s_valid),  32'(modelStdValid));
      check("std data",   32'(s_data),   32'(modelStdData));
      check("fwft count", 32'(f_count),  32'(n));
      check("fwft full",  32'(f_full),   32'(n == DEPTH));
      check("fwft empty", 32'(f_empty),  32'(n == 0));
      check("fwft afull", 32'(f_afull),  32'(n >= AFT));
      check("fwft aempty",32'(f_aempty), 32'(n <= AET));
      check("fwft ovf",   32'(f_ovf),    32'(modelOvf));
      check("fwft udf",   32'(f_udf),    32'(modelUdf));
      check("fwft valid", 32'(f_valid),  32'(n != 0));
      if (n != 0) check("fwft data", 32'(f_data), 32'(modelQ[0]));
   endtask

   // Drive one cycle of inputs, let the edge happen, then compare.
   task automatic applyStimulus(input bit w, input logic [DW-1:0] d, input bit r,
                                input bit f, input bit rs);
      wr_en   = w;
      wr_data = d;
      rd_en   = r;
      flush   = f;
      rst     = rs;
      @(posedge clk);
      modelStep(w, d, r, f, rs);
      #1;
      checkOutput();
   endtask

   initial begin
      // Reset
      applyStimulus(0, 8'h00, 0, 0, 1);
      applyStimulus(0, 8'h00, 0, 0, 1);
      applyStimulus(0, 8'h00, 0, 0, 0);

      // Fill and drain, including a dropped write at full
      applyStimulus(1, 8'hA1, 0, 0, 0);
      applyStimulus(1, 8'hA2, 0, 0, 0);
      applyStimulus(1, 8'hA3, 0, 0, 0);
      applyStimulus(1, 8'hA4, 0, 0, 0);
      applyStimulus(1, 8'hFF, 0, 0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 1, 0, 0);
      applyStimulus(0, 8'h00, 0, 0, 0);
      applyStimulus(0, 8'h00, 1, 0, 0);
      applyStimulus(0, 8'h00, 0, 0, 1'b0);
      applyStimulus(1, 8'hEE, 1, 1, 0);
      applyStimulus(0, 8'h00, 0, 0, 0);

      // Simultaneous access, then write+read at full
      applyStimulus(1, 8'h10, 0, 0, 0);
      applyStimulus(1, 8'h11, 0, 0, 0);
      applyStimulus(1, 8'h12, 1, 0, 0);
      applyStimulus(1, 8'h13, 0, 0, 0);
      applyStimulus(1, 8'h14, 0, 0, 0);
      applyStimulus(1, 8'h15, 1, 0, 0);
      applyStimulus(0, 8'h00, 0, 1, 0);

      // Wrap-around with count kept at most 1
      applyStimulus(1, 8'h00, 0, 0, 0);
      for (int i = 1; i < 10; i++) applyStimulus(1, 8'(i), 1, 0, 0);
      applyStimulus(0, 8'h00, 1, 0, 0);
      applyStimulus(0, 8'h00, 0, 0, 0);

      // FWFT head presentation and consume
      applyStimulus(1, 8'h5A, 0, 0, 0);
      applyStimulus(0, 8'h00, 0, 0, 0);
      applyStimulus(0, 8'h00, 1, 0, 0);
      applyStimulus(0, 8'h00, 0, 0, 0);

      // Flush mid-operation with a concurrent write
      applyStimulus(1, 8'h31, 0, 0, 0);
      applyStimulus(1, 8'h32, 0, 0, 0);
      applyStimulus(1, 8'h33, 1, 0, 0);
      applyStimulus(1, 8'h34, 0, 0, 0);
      applyStimulus(1, 8'h35, 0, 1, 0);
      applyStimulus(0, 8'h00, 0, 0, 0);

      // Reset mid-operation with a concurrent write
      applyStimulus(1, 8'h41, 0, 0, 0);
      applyStimulus(1, 8'h42, 0, 0, 0);
      applyStimulus(1, 8'h43, 1, 0, 0);
      applyStimulus(1, 8'h44, 0, 0, 0);
      applyStimulus(1, 8'h45, 0, 0, 1);
      applyStimulus(0, 8'h00, 0, 0, 0);

      // Randomised traffic with occasional flush and reset
      for (int i = 0; i < 500; i++) begin
         applyStimulus(bit'($urandom_range(0, 99) < 55), 8'($urandom),
                       bit'($urandom_range(0, 99) < 50),
                       bit'($urandom_range(0, 63) == 0),
                       bit'($urandom_range(0, 127) == 0));
      end

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
